// File: rtl/punc_fetch.sv
// Instruction fetch unit for an LC3-style core.
// It requests one word at pc, captures it into ir and offers it to the control unit.
// Redirects that arrive while a read is outstanding are held until the ack, and the
// returned word is then discarded.
module punc_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,

    // Instruction memory read port
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,

    // Control unit handshake
    output logic [15:0] ir,
    output logic [15:0] pc,
    output logic        ir_valid,
    input  logic        ir_ready,

    // Control flow
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    output logic        halted
);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StHold,
        StHalted
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    // A redirect seen while a read is outstanding; the read must still finish
    // before pc can move, so the target waits here.
    logic        pend_q, pend_d;
    logic [15:0] pend_pc_q, pend_pc_d;

    assign pc       = pc_q;
    assign ir       = ir_q;
    // pc only changes on an ack, so the address is stable for the whole request.
    assign mem_addr = pc_q;

    // Next-state and datapath update decisions.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;

        case (state_q)
            StIdle: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end
                state_d = halt ? StHalted : StFetch;
            end

            StFetch: begin
                if (mem_ack) begin
                    if (pend_q || redirect) begin
                        // Word fetched from the old stream is dropped; a same-cycle
                        // redirect is newer than the latched one.
                        pc_d    = redirect ? redirect_pc : pend_pc_q;
                        pend_d  = 1'b0;
                        state_d = StIdle;
                    end else begin
                        ir_d    = mem_rdata;
                        pc_d    = pc_q + 16'd1;
                        state_d = StHold;
                    end
                end else if (redirect) begin
                    pend_d    = 1'b1;
                    pend_pc_d = redirect_pc;
                end
            end

            StHold: begin
                if (redirect) begin
                    // Redirect beats acceptance: the held word is squashed.
                    pc_d    = redirect_pc;
                    state_d = StIdle;
                end else if (ir_ready) begin
                    state_d = halt ? StHalted : StFetch;
                end
            end

            StHalted: begin
                state_d = StHalted;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; outputs are registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            pc_q      <= RESET_PC;
            ir_q      <= 16'h0000;
            pend_q    <= 1'b0;
            pend_pc_q <= 16'h0000;
            mem_req   <= 1'b0;
            ir_valid  <= 1'b0;
            halted    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
            mem_req   <= (state_d == StFetch);
            ir_valid  <= (state_d == StHold);
            halted    <= (state_d == StHalted);
        end
    end

endmodule

// File: tb/tb_punc_fetch.sv
// Directed bench for punc_fetch: reset, capture, wrap, redirects, halt and stale acks.
module tb_punc_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] ir;
    logic [15:0] pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        halted;

    int n_total  = 0;
    int n_passed = 0;

    punc_fetch #(.RESET_PC(16'h0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .ir         (ir),
        .pc         (pc),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halt       (halt),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    // Advance one clock; sample and drive 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    initial begin
        rst         = 1'b1;
        mem_ack     = 1'b0;
        mem_rdata   = 16'h0000;
        ir_ready    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        halt        = 1'b0;
        step();
        step();

        // Reset state
        check("rst_mem_req", {15'd0, mem_req}, 16'd0);
        check("rst_ir_valid", {15'd0, ir_valid}, 16'd0);
        check("rst_halted", {15'd0, halted}, 16'd0);
        check("rst_pc", pc, 16'h0000);
        check("rst_ir", ir, 16'h0000);

        // Basic fetch of 16'h1234 from address 0
        rst = 1'b0;
        step();
        check("f1_mem_req", {15'd0, mem_req}, 16'd1);
        check("f1_mem_addr", mem_addr, 16'h0000);
        step();
        check("f1_req_held", {15'd0, mem_req}, 16'd1);
        mem_ack = 1'b1; mem_rdata = 16'h1234;
        step();
        mem_ack = 1'b0;
        check("f1_ir", ir, 16'h1234);
        check("f1_pc", pc, 16'h0001);
        check("f1_ir_valid", {15'd0, ir_valid}, 16'd1);
        check("f1_req_off", {15'd0, mem_req}, 16'd0);
        step();
        step();
        check("f1_valid_held", {15'd0, ir_valid}, 16'd1);
        check("f1_ir_stable", ir, 16'h1234);
        ir_ready = 1'b1;
        step();
        ir_ready = 1'b0;
        check("f2_valid_drop", {15'd0, ir_valid}, 16'd0);
        check("f2_mem_req", {15'd0, mem_req}, 16'd1);
        check("f2_mem_addr", mem_addr, 16'h0001);

        // Capture 16'h5555, then redirect from HOLD to 16'hFFFF
        step();
        mem_ack = 1'b1; mem_rdata = 16'h5555;
        step();
        mem_ack = 1'b0;
        check("f2_ir", ir, 16'h5555);
        check("f2_pc", pc, 16'h0002);
        redirect = 1'b1; redirect_pc = 16'hFFFF;
        step();
        redirect = 1'b0;
        check("hr_ir_valid", {15'd0, ir_valid}, 16'd0);
        check("hr_pc", pc, 16'hFFFF);
        check("hr_mem_req", {15'd0, mem_req}, 16'd0);

        // PC wrap: fetch 16'hF025 at 16'hFFFF
        step();
        check("wrap_mem_addr", mem_addr, 16'hFFFF);
        check("wrap_mem_req", {15'd0, mem_req}, 16'd1);
        step();
        mem_ack = 1'b1; mem_rdata = 16'hF025;
        step();
        mem_ack = 1'b0;
        check("wrap_ir", ir, 16'hF025);
        check("wrap_pc", pc, 16'h0000);
        check("wrap_ir_valid", {15'd0, ir_valid}, 16'd1);

        // Redirect to 16'h3000 while the fetch of 16'hAAAA is outstanding
        ir_ready = 1'b1;
        step();
        ir_ready = 1'b0;
        check("pr_mem_addr0", mem_addr, 16'h0000);
        step();
        redirect = 1'b1; redirect_pc = 16'h3000;
        step();
        redirect = 1'b0;
        check("pr_req_held", {15'd0, mem_req}, 16'd1);
        check("pr_addr_held", mem_addr, 16'h0000);
        check("pr_no_valid", {15'd0, ir_valid}, 16'd0);
        mem_ack = 1'b1; mem_rdata = 16'hAAAA;
        step();
        mem_ack = 1'b0;
        check("pr_ir_kept", ir, 16'hF025);
        check("pr_no_valid2", {15'd0, ir_valid}, 16'd0);
        check("pr_pc", pc, 16'h3000);
        step();
        check("pr_next_addr", mem_addr, 16'h3000);
        check("pr_next_req", {15'd0, mem_req}, 16'd1);

        // Latched redirect overtaken by a redirect in the ack cycle
        redirect = 1'b1; redirect_pc = 16'h1111;
        step();
        redirect = 1'b1; redirect_pc = 16'h2222;
        mem_ack = 1'b1; mem_rdata = 16'hBBBB;
        step();
        redirect = 1'b0; mem_ack = 1'b0;
        check("sr_pc", pc, 16'h2222);
        check("sr_ir_kept", ir, 16'hF025);
        check("sr_no_valid", {15'd0, ir_valid}, 16'd0);
        step();
        check("sr_next_addr", mem_addr, 16'h2222);
        step();
        mem_ack = 1'b1; mem_rdata = 16'h7777;
        step();
        mem_ack = 1'b0;
        check("sr_ir", ir, 16'h7777);
        check("sr_next_pc", pc, 16'h2223);

        // HOLD with redirect and ir_ready together: redirect wins
        redirect = 1'b1; ir_ready = 1'b1; redirect_pc = 16'h0400;
        step();
        redirect = 1'b0; ir_ready = 1'b0;
        check("hw_ir_valid", {15'd0, ir_valid}, 16'd0);
        check("hw_mem_req", {15'd0, mem_req}, 16'd0);
        check("hw_pc", pc, 16'h0400);
        step();
        check("hw_mem_addr", mem_addr, 16'h0400);
        check("hw_ir_kept", ir, 16'h7777);
        step();
        mem_ack = 1'b1; mem_rdata = 16'h1111;
        step();
        mem_ack = 1'b0;
        check("hw_ir", ir, 16'h1111);
        check("hw_next_pc", pc, 16'h0401);

        // Halt raised during FETCH: fetch completes, then halts after acceptance
        ir_ready = 1'b1;
        step();
        ir_ready = 1'b0;
        halt = 1'b1;
        step();
        check("ht_req_held", {15'd0, mem_req}, 16'd1);
        mem_ack = 1'b1; mem_rdata = 16'h2468;
        step();
        mem_ack = 1'b0;
        check("ht_ir", ir, 16'h2468);
        check("ht_ir_valid", {15'd0, ir_valid}, 16'd1);
        check("ht_not_halted", {15'd0, halted}, 16'd0);
        step();
        check("ht_valid_held", {15'd0, ir_valid}, 16'd1);
        ir_ready = 1'b1;
        step();
        check("ht_halted", {15'd0, halted}, 16'd1);
        check("ht_ir_valid_off", {15'd0, ir_valid}, 16'd0);
        halt = 1'b0;
        for (int i = 0; i < 20; i++) begin
            redirect    = i[0];
            redirect_pc = 16'h6000;
            mem_ack     = i[1];
            step();
            check("hs_mem_req", {15'd0, mem_req}, 16'd0);
            check("hs_halted", {15'd0, halted}, 16'd1);
            check("hs_pc", pc, 16'h0402);
        end
        redirect = 1'b0; mem_ack = 1'b0; ir_ready = 1'b0;

        // Reset mid-FETCH, stale ack during and after reset is ignored
        rst = 1'b1;
        step();
        check("rr_halted_clr", {15'd0, halted}, 16'd0);
        rst = 1'b0;
        step();
        check("rr_fetch", {15'd0, mem_req}, 16'd1);
        step();
        rst = 1'b1; mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        step();
        check("rr_req_off", {15'd0, mem_req}, 16'd0);
        rst = 1'b0;
        step();
        mem_ack = 1'b0;
        check("rr_ir", ir, 16'h0000);
        check("rr_pc", pc, 16'h0000);
        check("rr_ir_valid", {15'd0, ir_valid}, 16'd0);
        check("rr_refetch", {15'd0, mem_req}, 16'd1);
        step();
        mem_ack = 1'b1; mem_rdata = 16'h0F0F;
        step();
        mem_ack = 1'b0;
        check("rr_ir_new", ir, 16'h0F0F);
        check("rr_pc_new", pc, 16'h0001);

        // Redirect while IDLE
        rst = 1'b1;
        step();
        rst = 1'b0; redirect = 1'b1; redirect_pc = 16'h5000;
        step();
        redirect = 1'b0;
        check("ir_idle_addr", mem_addr, 16'h5000);
        check("ir_idle_req", {15'd0, mem_req}, 16'd1);

        // Halt while IDLE goes straight to HALTED
        rst = 1'b1;
        step();
        rst = 1'b0; halt = 1'b1;
        step();
        halt = 1'b0;
        check("hi_halted", {15'd0, halted}, 16'd1);
        check("hi_mem_req", {15'd0, mem_req}, 16'd0);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule

// File: doc/punc_fetch.md
PUNC_FETCH -- requirements
Module: punc_fetch

Interface
REQ-001 Parameter: RESET_PC, 16'h0000, PC value loaded on reset.
REQ-002 clk  input  1  system clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 mem_req  output  1  instruction-memory read request.
REQ-005 mem_addr  output  16  read address; equals pc whenever mem_req=1.
REQ-006 mem_ack  input  1  one-cycle pulse: mem_rdata valid this cycle; arrives >=1 cycle after mem_req rises.
REQ-007 mem_rdata  input  16  instruction word, sampled only when mem_ack=1.
REQ-008 ir  output  16  latched instruction register.
REQ-009 pc  output  16  program counter; after a capture, address of the next instruction (LC3 incremented PC).
REQ-010 ir_valid  output  1  ir holds an instruction not yet accepted by the control unit.
REQ-011 ir_ready  input  1  control unit accepts ir this cycle.
REQ-012 redirect  input  1  one-cycle pulse: load pc from redirect_pc (branch/JMP/JSR/TRAP).
REQ-013 redirect_pc  input  16  redirect target.
REQ-014 halt  input  1  level: stop fetching.
REQ-015 halted  output  1  fetch stopped; sticky until rst.

Function
REQ-016 States SHALL be IDLE, FETCH, HOLD, HALTED; outputs decoded from state only (Moore), except mem_addr = pc.
REQ-017 IDLE: all outputs inactive; next state FETCH, or HALTED if halt=1.
REQ-018 FETCH: mem_req=1 continuously until mem_ack; mem_req SHALL NOT drop before mem_ack.
REQ-019 FETCH with mem_ack, no pending redirect: ir<=mem_rdata, pc<=pc+1 (mod 2^16, 16'hFFFF->16'h0000), next HOLD.
REQ-020 FETCH with redirect: set internal pending flag, latch target; mem_req stays high; mem_addr unchanged until ack.
REQ-021 FETCH with mem_ack and pending (or redirect the same cycle): discard mem_rdata, ir unchanged, pc<=latched target (same-cycle redirect_pc wins over earlier latched), clear flag, next IDLE.
REQ-022 HOLD: ir_valid=1; ir and pc stable.
REQ-023 HOLD with ir_ready, no redirect: next FETCH, or HALTED if halt=1; ir_valid low the following cycle.
REQ-024 HOLD with redirect (with or without ir_ready): pc<=redirect_pc, ir_valid drops next cycle, next IDLE; redirect wins over ir_ready.
REQ-025 IDLE with redirect: pc<=redirect_pc, transition per REQ-017.
REQ-026 halt is sampled only on entry decisions in IDLE and HOLD+ir_ready; an in-flight FETCH always completes.
REQ-027 HALTED: halted=1, all other outputs inactive; redirect, halt, ir_ready, mem_ack ignored; exit only via rst.
REQ-028 Minimum throughput: one instruction per 3 cycles with 1-cycle memory latency and ir_ready held high.

Reset
REQ-029 rst=1 SHALL force state IDLE, pc=RESET_PC, ir=16'h0000, pending flag clear, mem_req=0, ir_valid=0, halted=0 on the next edge.
REQ-030 rst SHALL override all inputs, including mid-FETCH; a mem_ack arriving during or after reset for the abandoned request SHALL be ignored (ack outside FETCH has no effect).

Verification
REQ-031 Reset, memory returns 16'h1234 one cycle after mem_req -> mem_addr=16'h0000, then ir=16'h1234, pc=16'h0001, ir_valid=1 held until ir_ready.
REQ-032 pc=16'hFFFF, fetch 16'hF025 -> ir=16'hF025, pc wraps to 16'h0000.
REQ-033 Redirect to 16'h3000 while FETCH awaits 3-cycle ack of 16'hAAAA -> ir unchanged, ir_valid never rises for 16'hAAAA, next mem_addr=16'h3000.
REQ-034 HOLD with redirect=1 and ir_ready=1 same cycle, redirect_pc=16'h0400 -> next fetch mem_addr=16'h0400, no extra acceptance.
REQ-035 halt=1 asserted during FETCH -> transaction completes, ir_valid until ir_ready, then halted=1, mem_req stays 0 for 20 cycles despite redirect pulses.
REQ-036 rst pulse mid-FETCH followed by stale mem_ack in IDLE -> ir=16'h0000, pc=RESET_PC, ir_valid=0.
